// File: rtl/atm_bank_pkg.sv
// atm_bank_pkg: shared types, sizes and reset image
// for the ATM account server and its lookup scanner.
package atm_bank_pkg;

  localparam int NUM_ACCOUNTS  = 4;
  localparam int ACCT_W        = 16;
  localparam int PIN_W         = 14;
  localparam int BAL_W         = 32;
  localparam int MAX_PIN_TRIES = 3;
  localparam int FAIL_W        = $clog2(MAX_PIN_TRIES + 1);
  localparam int IDX_W         =
    (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int RESET_ENTRIES = 4;
  localparam int RI_W          = $clog2(RESET_ENTRIES);

  typedef enum logic [2:0] {
    OP_CLOSE      = 3'd0,
    OP_BALANCE    = 3'd1,
    OP_WITHDRAW   = 3'd2,
    OP_DEPOSIT    = 3'd3,
    OP_TRANSFER   = 3'd4,
    OP_CHANGE_PIN = 3'd5,
    OP_AUTH       = 3'd6,
    OP_RSVD       = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_NO_ACCOUNT   = 3'd1,
    ST_BAD_PIN      = 3'd2,
    ST_LOCKED       = 3'd3,
    ST_INSUFFICIENT = 3'd4,
    ST_REJECT       = 3'd5,
    ST_SAME_ACCOUNT = 3'd6,
    ST_OVERFLOW     = 3'd7
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [ACCT_W-1:0] acct;
    logic [PIN_W-1:0]  pin;
    logic [BAL_W-1:0]  balance;
    logic [FAIL_W-1:0] fails;
    logic              locked;
  } acct_rec_t;

  function automatic acct_rec_t mk_rec(
    input logic [ACCT_W-1:0] a,
    input logic [PIN_W-1:0]  p,
    input logic [BAL_W-1:0]  b
  );
    acct_rec_t r;
    r         = '0;
    r.acct    = a;
    r.pin     = p;
    r.balance = b;
    return r;
  endfunction

  localparam acct_rec_t [RESET_ENTRIES-1:0] RESET_IMG = {
    mk_rec(16'h86B9, 14'h0D05, 32'd3000),
    mk_rec(16'h3219, 14'h04D2, 32'd7500),
    mk_rec(16'h706C, 14'h04C7, 32'd8000),
    mk_rec(16'hC582, 14'h1F8E, 32'd5000)
  };

  // Entries past the image come up empty
  function automatic acct_rec_t reset_rec(input int idx);
    acct_rec_t r;
    r = '0;
    if (idx < RESET_ENTRIES)
      r = RESET_IMG[RI_W'(idx)];
    return r;
  endfunction

endpackage

// File: rtl/atm_account_lookup.sv
// atm_account_lookup: scans one table entry per cycle
// and reports the first matching index.
module atm_account_lookup
  import atm_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACCT_W-1:0] key,
  input  logic [ACCT_W-1:0] accts [NUM_ACCOUNTS],
  output logic              done,
  output logic              hit,
  output logic [IDX_W-1:0]  index
);

  logic              busy_q, busy_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  hidx_q, hidx_d;
  logic [ACCT_W-1:0] key_q, key_d;
  logic              cur_match;
  logic              last;

  assign cur_match = busy_q && (key_q != '0)
                     && (accts[idx_q] == key_q);
  assign last  = (idx_q == IDX_W'(NUM_ACCOUNTS - 1));
  assign done  = busy_q && last;
  assign hit   = hit_q || cur_match;
  assign index = hit_q ? hidx_q : idx_q;

  // Next scan position and first-hit capture
  always_comb begin
    busy_d = busy_q;
    hit_d  = hit_q;
    idx_d  = idx_q;
    hidx_d = hidx_q;
    key_d  = key_q;
    if (start) begin
      busy_d = 1'b1;
      hit_d  = 1'b0;
      idx_d  = '0;
      hidx_d = '0;
      key_d  = key;
    end else if (busy_q) begin
      if (cur_match && !hit_q) begin
        hit_d  = 1'b1;
        hidx_d = idx_q;
      end
      if (last)
        busy_d = 1'b0;
      else
        idx_d = idx_q + IDX_W'(1);
    end
  end

  // Scanner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      hit_q  <= 1'b0;
      idx_q  <= '0;
      hidx_q <= '0;
      key_q  <= '0;
    end else begin
      busy_q <= busy_d;
      hit_q  <= hit_d;
      idx_q  <= idx_d;
      hidx_q <= hidx_d;
      key_q  <= key_d;
    end
  end

endmodule

// File: rtl/atm_account_server.sv
// atm_account_server: bank-side responder owning the
// account table; one request in flight at a time.
module atm_account_server
  import atm_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ACCT_W-1:0] req_acct,
  input  logic [PIN_W-1:0]  req_pin,
  input  logic [ACCT_W-1:0] req_dst_acct,
  input  logic [BAL_W-1:0]  req_amount,
  input  logic [PIN_W-1:0]  req_new_pin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [BAL_W-1:0]  rsp_balance,
  output logic              session_active
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [PIN_W-1:0]  npin_q, npin_d;
  logic [BAL_W-1:0]  amt_q, amt_d;
  logic              sess_q, sess_d;
  logic [IDX_W-1:0]  sidx_q, sidx_d;
  logic              lk_hit_q, lk_hit_d;
  logic [IDX_W-1:0]  lk_idx_q, lk_idx_d;
  acct_rec_t         tbl_q [NUM_ACCOUNTS];
  acct_rec_t         tbl_d [NUM_ACCOUNTS];
  logic              rsp_valid_q, rsp_valid_d;
  status_e           st_q, st_d;
  logic [BAL_W-1:0]  bal_q, bal_d;

  logic              accept;
  logic              needs_lk;
  logic              lk_start;
  logic [ACCT_W-1:0] lk_key;
  logic [ACCT_W-1:0] accts [NUM_ACCOUNTS];
  logic              lk_done;
  logic              lk_hit;
  logic [IDX_W-1:0]  lk_idx;
  logic [BAL_W-1:0]  src_bal;
  logic [BAL_W-1:0]  dst_bal;
  logic [BAL_W:0]    dep_sum;
  logic [BAL_W:0]    xfr_sum;
  logic [FAIL_W-1:0] fails_n;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign needs_lk = (req_op == OP_AUTH)
                    || (req_op == OP_TRANSFER);
  assign lk_start = accept && needs_lk;
  assign lk_key   = (req_op == OP_AUTH)
                    ? req_acct : req_dst_acct;

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_status     = st_q;
  assign rsp_balance    = bal_q;
  assign session_active = sess_q;

  // Account numbers presented to the scanner
  always_comb begin
    for (int i = 0; i < NUM_ACCOUNTS; i++)
      accts[IDX_W'(i)] = tbl_q[IDX_W'(i)].acct;
  end

  atm_account_lookup u_lookup (
    .clk   (clk),
    .rst   (rst),
    .start (lk_start),
    .key   (lk_key),
    .accts (accts),
    .done  (lk_done),
    .hit   (lk_hit),
    .index (lk_idx)
  );

  // Sequencing, request evaluation and table commit
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pin_d       = pin_q;
    npin_d      = npin_q;
    amt_d       = amt_q;
    sess_d      = sess_q;
    sidx_d      = sidx_q;
    lk_hit_d    = lk_hit_q;
    lk_idx_d    = lk_idx_q;
    tbl_d       = tbl_q;
    rsp_valid_d = rsp_valid_q;
    st_d        = st_q;
    bal_d       = bal_q;
    src_bal     = tbl_q[sidx_q].balance;
    dst_bal     = tbl_q[lk_idx_q].balance;
    dep_sum     = {1'b0, src_bal} + {1'b0, amt_q};
    xfr_sum     = {1'b0, dst_bal} + {1'b0, amt_q};
    fails_n     = tbl_q[lk_idx_q].fails + FAIL_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          pin_d   = req_pin;
          npin_d  = req_new_pin;
          amt_d   = req_amount;
          state_d = needs_lk ? S_LOOKUP : S_EXEC;
        end
      end
      S_LOOKUP: begin
        if (lk_done) begin
          lk_hit_d = lk_hit;
          lk_idx_d = lk_idx;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        st_d = ST_OK;
        if ((op_q == OP_RSVD)
            || (!sess_q && (op_q != OP_CLOSE)
                && (op_q != OP_AUTH))) begin
          st_d = ST_REJECT;
        end else begin
          unique case (op_q)
            OP_CLOSE: sess_d = 1'b0;
            OP_WITHDRAW: begin
              if (amt_q > src_bal)
                st_d = ST_INSUFFICIENT;
              else
                tbl_d[sidx_q].balance = src_bal - amt_q;
            end
            OP_DEPOSIT: begin
              if (dep_sum[BAL_W])
                st_d = ST_OVERFLOW;
              else
                tbl_d[sidx_q].balance = dep_sum[BAL_W-1:0];
            end
            OP_TRANSFER: begin
              if (!lk_hit_q)
                st_d = ST_NO_ACCOUNT;
              else if (lk_idx_q == sidx_q)
                st_d = ST_SAME_ACCOUNT;
              else if (amt_q > src_bal)
                st_d = ST_INSUFFICIENT;
              else if (xfr_sum[BAL_W])
                st_d = ST_OVERFLOW;
              else begin
                tbl_d[sidx_q].balance = src_bal - amt_q;
                tbl_d[lk_idx_q].balance =
                  xfr_sum[BAL_W-1:0];
              end
            end
            OP_CHANGE_PIN: tbl_d[sidx_q].pin = npin_q;
            OP_AUTH: begin
              sess_d = 1'b0;
              if (!lk_hit_q)
                st_d = ST_NO_ACCOUNT;
              else if (tbl_q[lk_idx_q].locked)
                st_d = ST_LOCKED;
              else if (pin_q != tbl_q[lk_idx_q].pin) begin
                tbl_d[lk_idx_q].fails = fails_n;
                if (fails_n >= FAIL_W'(MAX_PIN_TRIES)) begin
                  tbl_d[lk_idx_q].locked = 1'b1;
                  st_d = ST_LOCKED;
                end else begin
                  st_d = ST_BAD_PIN;
                end
              end else begin
                tbl_d[lk_idx_q].fails = '0;
                sess_d = 1'b1;
                sidx_d = lk_idx_q;
              end
            end
            default: st_d = ST_OK;
          endcase
        end
        bal_d = sess_d ? tbl_d[sidx_d].balance : '0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, table and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CLOSE;
      pin_q       <= '0;
      npin_q      <= '0;
      amt_q       <= '0;
      sess_q      <= 1'b0;
      sidx_q      <= '0;
      lk_hit_q    <= 1'b0;
      lk_idx_q    <= '0;
      rsp_valid_q <= 1'b0;
      st_q        <= ST_OK;
      bal_q       <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++)
        tbl_q[IDX_W'(i)] <= reset_rec(i);
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pin_q       <= pin_d;
      npin_q      <= npin_d;
      amt_q       <= amt_d;
      sess_q      <= sess_d;
      sidx_q      <= sidx_d;
      lk_hit_q    <= lk_hit_d;
      lk_idx_q    <= lk_idx_d;
      rsp_valid_q <= rsp_valid_d;
      st_q        <= st_d;
      bal_q       <= bal_d;
      tbl_q       <= tbl_d;
    end
  end

endmodule

// File: doc/atm_account_server.md
Name: atm_account_server

Overview:
- Bank-side responder for the ATM controller: owns the account table (number, PIN, balance), authenticates card sessions and executes balance/withdraw/deposit/transfer/change-PIN requests.
- Single request/response valid-ready channel; one transaction in flight.
- Sits between the ATM front-end FSM and the account storage. All table updates commit on a single clock edge.

Parameters:
- NUM_ACCOUNTS, 4, table entries; entries beyond the 4-entry reset image reset to all-zero; account number 0 never matches.
- ACCT_W, 16, account number width.
- PIN_W, 14, PIN width.
- BAL_W, 32, balance and amount width, unsigned.
- MAX_PIN_TRIES, 3, consecutive failures that lock an account.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  3  0 CLOSE, 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 TRANSFER, 5 CHANGE_PIN, 6 AUTH, 7 reserved
- req_acct  in  ACCT_W  account for AUTH
- req_pin  in  PIN_W  PIN for AUTH
- req_dst_acct  in  ACCT_W  TRANSFER destination
- req_amount  in  BAL_W  WITHDRAW/DEPOSIT/TRANSFER amount
- req_new_pin  in  PIN_W  CHANGE_PIN value
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_status  out  3  0 OK, 1 NO_ACCOUNT, 2 BAD_PIN, 3 LOCKED, 4 INSUFFICIENT, 5 REJECT, 6 SAME_ACCOUNT, 7 OVERFLOW
- rsp_balance  out  BAL_W  session balance after the op; 0 if no session
- session_active  out  1  authenticated session open

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0, session_active=0.
  - Fail counters and lock bits clear.
  - Table loads the image {C582,1F8E,5000}, {706C,04C7,8000}, {3219,04D2,7500}, {86B9,0D05,3000}.
  - Reset mid-transaction aborts with no partial update.
- Accept: req_valid & req_ready at an edge latches all req_* fields. Later input changes are ignored.
- FSM: IDLE -> LOOKUP (AUTH, TRANSFER only) -> EXEC -> RESP -> IDLE.
  - All other ops go IDLE -> EXEC.
  - LOOKUP scans one entry per cycle, indices 0..NUM_ACCOUNTS-1, always the full NUM_ACCOUNTS cycles. The first match wins.
  - EXEC evaluates and commits the table update on its exit edge.
  - RESP holds rsp_valid and fields stable until rsp_ready. It returns to IDLE on the handshake edge.
- Latency: rsp_valid rises NUM_ACCOUNTS+2 cycles after accept for AUTH/TRANSFER, 2 cycles for other ops.
- AUTH:
  - Any open session is closed first.
  - No match -> NO_ACCOUNT.
  - Lock bit set -> LOCKED, even with the correct PIN.
  - Wrong PIN -> increment the fail counter. Response is BAD_PIN, or LOCKED when the counter reaches MAX_PIN_TRIES, which also sets the lock bit.
  - Correct PIN -> counter=0, session opens on that index, OK.
  - Lock clears only on rst.
- No session and op in {1,2,3,4,5}, or op 7 -> REJECT, no state change.
- CLOSE: session_active=0, OK; idempotent.
- WITHDRAW:
  - amount > balance -> INSUFFICIENT.
  - Otherwise balance -= amount.
  - amount == balance yields 0; amount 0 gives OK with no change.
- DEPOSIT: sum exceeds 2^BAL_W-1 -> OVERFLOW, unchanged; otherwise add.
- TRANSFER: checks apply in this priority order:
  - dst not found -> NO_ACCOUNT.
  - dst == session index -> SAME_ACCOUNT.
  - amount > source balance -> INSUFFICIENT.
  - dst overflow -> OVERFLOW.
  - Otherwise source and destination both update on the same edge.
- CHANGE_PIN: writes req_new_pin, OK; the fail counter is unchanged.
- rsp_balance: session account balance after commit; 0 when status is non-OK for AUTH, and after CLOSE.

Decomposition:
- Package atm_bank_pkg holds:
  - opcode and status enums;
  - FSM state enum;
  - account record typedef {acct, pin, balance, fails, locked};
  - 4-entry reset image constant.
- Sub-module atm_account_lookup: sequential scanner.
  - Inputs: start, key.
  - Outputs: done, hit, index.
  - Done exactly NUM_ACCOUNTS cycles after start.

Test Plan:
- Reset, AUTH C582/1F8E -> rsp_valid 6 cycles after accept, OK, balance 5000, session_active=1.
- AUTH 706C with PIN 0000 three times -> BAD_PIN, BAD_PIN, LOCKED. Then AUTH 706C/04C7 -> LOCKED, session_active=0.
- Session C582: WITHDRAW 5001 -> INSUFFICIENT, 5000. WITHDRAW 5000 -> OK, 0. DEPOSIT FFFFFFFF onto 1 -> OVERFLOW.
- Session 3219/04D2:
  - TRANSFER 7500 to 86B9 -> OK, 0.
  - TRANSFER to 3219 -> SAME_ACCOUNT.
  - TRANSFER to 1234 -> NO_ACCOUNT.
  - AUTH 86B9/0D05 -> OK, 10500.
- BALANCE after reset with no session -> REJECT, balance 0. Op 7 in session -> REJECT.
- Backpressure and reset abort:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and fields stable, req_ready=0.
  - Assert rst during LOOKUP of a TRANSFER -> rsp_valid=0 next cycle, all balances equal the reset image.
